// File: rtl/nco_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// nco_sweep_ctrl
//
// Sequencer for the 16-bit frequency control word of the sine NCO. Steps the
// word linearly from a start value to a stop value, holding every value for
// dwell+1 clocks. Supports one-shot, repeating sawtooth and continuous
// triangle sweeps (chirp / frequency-response stimulus). The NCO output
// frequency is clk/(control*256), so 16'hFFFF is the slowest rate.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle sweep request, honoured only while idle
//   abort       synchronous stop; control keeps its current value
//   mode        0 one-shot, 1 sawtooth repeat, 2 triangle, 3 behaves as 0
//   start_word  first control word of the sweep
//   stop_word   last control word of the sweep
//   step        magnitude of each increment/decrement
//   dwell       each word is held for dwell+1 cycles
//   control     registered control word to the NCO
//   busy        high while a sweep is running
//   done        one-cycle pulse when a one-shot sweep completes
// ---------------------------------------------------------------------------
module nco_sweep_ctrl #(
    parameter int CW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] start_word,
    input  logic [CW-1:0] stop_word,
    input  logic [CW-1:0] step,
    input  logic [DW-1:0] dwell,
    output logic [CW-1:0] control,
    output logic          busy,
    output logic          done
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DWELL = 1'b1;

    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;

    localparam logic [DW-1:0] DWELL_ONE = DW'(1);
    localparam logic [CW-1:0] CTRL_SLOW = {CW{1'b1}};

    logic          state;
    logic [DW-1:0] dwell_cnt;
    logic          dir_up;
    // Set while a triangle sweep travels back from stop_word to start_word.
    logic          returning;

    logic [CW-1:0] cfg_start;
    logic [CW-1:0] cfg_stop;
    logic [CW-1:0] cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;

    logic [CW-1:0] end_word;
    logic [CW-1:0] turn_end;
    logic [CW-1:0] next_word;
    logic [CW-1:0] turn_word;

    // Upward step, saturating at end_w. The sum is one bit wider so that a
    // carry out of the word is caught instead of wrapping to a fast rate.
    // A zero step jumps straight to the end so the sweep cannot stall.
    function automatic logic [CW-1:0] step_up(
        input logic [CW-1:0] cur,
        input logic [CW-1:0] end_w,
        input logic [CW-1:0] stp
    );
        logic [CW:0] sum;
        sum = {1'b0, cur} + {1'b0, stp};
        if (stp == '0 || sum[CW] || sum[CW-1:0] >= end_w)
            return end_w;
        return sum[CW-1:0];
    endfunction

    // Downward step, saturating at end_w. Distance to the end is compared
    // against the step before subtracting, so no underflow can occur.
    function automatic logic [CW-1:0] step_down(
        input logic [CW-1:0] cur,
        input logic [CW-1:0] end_w,
        input logic [CW-1:0] stp
    );
        logic [CW-1:0] diff;
        if (stp == '0 || cur <= end_w)
            return end_w;
        diff = cur - end_w;
        if (diff <= stp)
            return end_w;
        return cur - stp;
    endfunction

    assign end_word  = returning ? cfg_start : cfg_stop;
    // At a triangle turn-around the target end and direction both flip, and
    // the first step back is taken on the same edge so the peak word is not
    // held for an extra dwell period.
    assign turn_end  = returning ? cfg_stop : cfg_start;
    assign next_word = dir_up ? step_up(control, end_word, cfg_step)
                              : step_down(control, end_word, cfg_step);
    assign turn_word = dir_up ? step_down(control, turn_end, cfg_step)
                              : step_up(control, turn_end, cfg_step);

    assign busy = (state == ST_DWELL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            control   <= CTRL_SLOW;
            done      <= 1'b0;
            dwell_cnt <= '0;
            dir_up    <= 1'b1;
            returning <= 1'b0;
            cfg_start <= '0;
            cfg_stop  <= '0;
            cfg_step  <= '0;
            cfg_dwell <= '0;
            cfg_mode  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Abort outranks everything, including a same-cycle start.
                state <= ST_IDLE;
            end else if (state == ST_IDLE) begin
                if (start) begin
                    cfg_start <= start_word;
                    cfg_stop  <= stop_word;
                    cfg_step  <= step;
                    cfg_dwell <= dwell;
                    cfg_mode  <= mode;
                    control   <= start_word;
                    dwell_cnt <= dwell;
                    dir_up    <= (stop_word >= start_word);
                    returning <= 1'b0;
                    state     <= ST_DWELL;
                end
            end else if (dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - DWELL_ONE;
            end else if (control != end_word) begin
                control   <= next_word;
                dwell_cnt <= cfg_dwell;
            end else begin
                // End word reached after its full dwell.
                case (cfg_mode)
                    MODE_REPEAT: begin
                        control   <= cfg_start;
                        dwell_cnt <= cfg_dwell;
                    end
                    MODE_TRIANGLE: begin
                        returning <= ~returning;
                        dir_up    <= ~dir_up;
                        control   <= turn_word;
                        dwell_cnt <= cfg_dwell;
                    end
                    default: begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nco_sweep_ctrl
//
// Scoreboard bench for nco_sweep_ctrl. Each scenario pushes the expected
// per-cycle {control, busy, done} trace into a queue as it drives stimulus;
// every cycle one entry is popped and compared against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_nco_sweep_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] start_word;
    logic [15:0] stop_word;
    logic [15:0] step;
    logic [15:0] dwell;
    logic [15:0] control;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] ctrl;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t  sb[$];
    int    total;
    int    bad;
    string phase;

    nco_sweep_ctrl #(.CW(16), .DW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .start_word (start_word),
        .stop_word  (stop_word),
        .step       (step),
        .dwell      (dwell),
        .control    (control),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    task automatic push_w(input logic [15:0] w, input int n, input logic b, input logic d);
        exp_t e;
        e.ctrl = w;
        e.busy = b;
        e.done = d;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic compare_now();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val("control", {16'd0, control}, {16'd0, e.ctrl});
            check_val("busy", {31'd0, busy}, {31'd0, e.busy});
            check_val("done", {31'd0, done}, {31'd0, e.done});
        end
    endtask

    // Advance n clock edges, comparing outputs 1 ns after each edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            compare_now();
        end
    endtask

    task automatic drive_start(input logic [15:0] sw, input logic [15:0] ew,
                               input logic [15:0] st, input logic [15:0] dw,
                               input logic [1:0] md);
        start_word = sw;
        stop_word  = ew;
        step       = st;
        dwell      = dw;
        mode       = md;
        start      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'd0;
        start_word = '0;
        stop_word  = '0;
        step       = '0;
        dwell      = '0;

        // Reset state
        phase = "reset";
        repeat (2) @(posedge clk);
        #1;
        push_w(16'hFFFF, 1, 1'b0, 1'b0);
        compare_now();
        reset = 1'b1;
        push_w(16'hFFFF, 2, 1'b0, 1'b0);
        run(2);

        // Up one-shot: 100,104,108,110 each 3 cycles, then done pulse
        phase = "up_oneshot";
        drive_start(16'd100, 16'd110, 16'd4, 16'd2, 2'd0);
        push_w(16'd100, 1, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        push_w(16'd100, 2, 1'b1, 1'b0);
        push_w(16'd104, 3, 1'b1, 1'b0);
        push_w(16'd108, 3, 1'b1, 1'b0);
        push_w(16'd110, 3, 1'b1, 1'b0);
        push_w(16'd110, 1, 1'b0, 1'b1);
        push_w(16'd110, 2, 1'b0, 1'b0);
        run(14);

        // Down with saturation at the stop word
        phase = "down";
        drive_start(16'd50, 16'd40, 16'd3, 16'd0, 2'd0);
        push_w(16'd50, 1, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        push_w(16'd47, 1, 1'b1, 1'b0);
        push_w(16'd44, 1, 1'b1, 1'b0);
        push_w(16'd41, 1, 1'b1, 1'b0);
        push_w(16'd40, 1, 1'b1, 1'b0);
        push_w(16'd40, 1, 1'b0, 1'b1);
        push_w(16'd40, 1, 1'b0, 1'b0);
        run(6);

        // Up with carry out of the word: must clamp to FFFF, not wrap
        phase = "carry";
        drive_start(16'hFFF0, 16'hFFFF, 16'h0020, 16'd0, 2'd0);
        push_w(16'hFFF0, 1, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        push_w(16'hFFFF, 1, 1'b1, 1'b0);
        push_w(16'hFFFF, 1, 1'b0, 1'b1);
        push_w(16'hFFFF, 1, 1'b0, 1'b0);
        run(3);

        // Zero step jumps straight to the end word
        phase = "step0";
        drive_start(16'd20, 16'd30, 16'd0, 16'd0, 2'd0);
        push_w(16'd20, 1, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        push_w(16'd30, 1, 1'b1, 1'b0);
        push_w(16'd30, 1, 1'b0, 1'b1);
        run(2);

        // start_word == stop_word one-shot: held dwell+1 cycles then done
        phase = "equal";
        drive_start(16'd7, 16'd7, 16'd1, 16'd2, 2'd3);
        push_w(16'd7, 1, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        push_w(16'd7, 2, 1'b1, 1'b0);
        push_w(16'd7, 1, 1'b0, 1'b1);
        push_w(16'd7, 1, 1'b0, 1'b0);
        run(4);

        // Repeat sawtooth, then abort where the wrap back to 10 would occur
        phase = "repeat";
        drive_start(16'd10, 16'd12, 16'd1, 16'd1, 2'd1);
        push_w(16'd10, 1, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            push_w(16'd10, (r == 0) ? 1 : 2, 1'b1, 1'b0);
            push_w(16'd11, 2, 1'b1, 1'b0);
            push_w(16'd12, 2, 1'b1, 1'b0);
        end
        run(11);
        abort = 1'b1;
        push_w(16'd12, 1, 1'b0, 1'b0);
        run(1);
        abort = 1'b0;
        push_w(16'd12, 2, 1'b0, 1'b0);
        run(2);

        // Triangle: 10,12,13,11,10,12,13,11,10
        phase = "triangle";
        drive_start(16'd10, 16'd13, 16'd2, 16'd0, 2'd2);
        push_w(16'd10, 1, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        push_w(16'd12, 1, 1'b1, 1'b0);
        push_w(16'd13, 1, 1'b1, 1'b0);
        push_w(16'd11, 1, 1'b1, 1'b0);
        push_w(16'd10, 1, 1'b1, 1'b0);
        push_w(16'd12, 1, 1'b1, 1'b0);
        push_w(16'd13, 1, 1'b1, 1'b0);
        push_w(16'd11, 1, 1'b1, 1'b0);
        push_w(16'd10, 1, 1'b1, 1'b0);
        run(8);
        abort = 1'b1;
        push_w(16'd10, 1, 1'b0, 1'b0);
        run(1);
        abort = 1'b0;

        // Start while busy ignored; abort at 104 holds the word, no done
        phase = "abort";
        drive_start(16'd100, 16'd110, 16'd4, 16'd2, 2'd0);
        push_w(16'd100, 1, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        drive_start(16'd999, 16'd5, 16'd1, 16'd0, 2'd1);
        push_w(16'd100, 1, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        push_w(16'd100, 1, 1'b1, 1'b0);
        push_w(16'd104, 1, 1'b1, 1'b0);
        run(2);
        abort = 1'b1;
        push_w(16'd104, 1, 1'b0, 1'b0);
        run(1);
        abort = 1'b0;
        push_w(16'd104, 3, 1'b0, 1'b0);
        run(3);

        // Start and abort together in idle: stays idle
        phase = "start_abort";
        drive_start(16'd200, 16'd300, 16'd10, 16'd0, 2'd0);
        abort = 1'b1;
        push_w(16'd104, 1, 1'b0, 1'b0);
        run(1);
        start = 1'b0;
        abort = 1'b0;
        push_w(16'd104, 2, 1'b0, 1'b0);
        run(2);

        // Asynchronous reset mid-sweep, observed without a clock edge
        phase = "async_reset";
        drive_start(16'd100, 16'd110, 16'd4, 16'd2, 2'd1);
        push_w(16'd100, 1, 1'b1, 1'b0);
        run(1);
        start = 1'b0;
        push_w(16'd100, 1, 1'b1, 1'b0);
        run(1);
        #1;
        reset = 1'b0;
        #1;
        push_w(16'hFFFF, 1, 1'b0, 1'b0);
        compare_now();
        reset = 1'b1;
        push_w(16'hFFFF, 2, 1'b0, 1'b0);
        run(2);

        phase = "end";
        check_val("sb_left", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
- Sequencer that drives the 16-bit frequency control word of the sine NCO.
- Steps the word linearly from a start value to a stop value, holding each value for a programmable number of clocks.
- Supports one-shot, repeating-sawtooth and continuous-triangle sweeps; used for chirp and frequency-response test stimulus.
- Output `control` connects directly to the NCO `control` input. Output frequency is clk/(control*256).

Parameters:
- CW, 16, width of control/start/stop/step words
- DW, 16, width of dwell count

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE
- abort  input  1  stop sweep immediately; control holds its current value
- mode  input  2  0 one-shot, 1 repeat (sawtooth), 2 triangle, 3 reserved (acts as 0)
- start_word  input  CW  first control word of sweep
- stop_word  input  CW  last control word of sweep
- step  input  CW  magnitude of increment per update
- dwell  input  DW  each word is held for dwell+1 clk cycles
- control  output  CW  control word to NCO (registered)
- busy  output  1  high while sweeping (state DWELL)
- done  output  1  one-cycle pulse when a one-shot sweep completes

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, control=16'hFFFF (slowest frequency), busy=0, done=0, dwell_cnt=0, dir=up.
  - Latched config is cleared to 0.
- Config latching: on accepted start, latch start_word, stop_word, step and mode. Input changes during a sweep have no effect.
- States: IDLE, DWELL. Two states only; the update happens on the DWELL expiry edge.
- IDLE:
  - start=1 and abort=0 → control<=start_word, dwell_cnt<=dwell, dir<=up if stop_word>=start_word else down, state<=DWELL.
  - busy=1 from the following cycle; control changes on the same edge.
  - Otherwise control holds its value.
- DWELL, dwell_cnt!=0: dwell_cnt decrements.
- DWELL, dwell_cnt==0 and control!=end_word (end word is stop, or start when a triangle is returning):
  - up: next=control+step, computed CW+1 bits wide; if next>=end or carry, next=end.
  - down: if control-end<=step, next=end; else next=control-step.
  - control<=next, dwell_cnt<=dwell.
- DWELL, dwell_cnt==0 and control==end_word (end reached):
  - mode 0/3: state<=IDLE, busy<=0, done<=1 for exactly one cycle, control holds stop_word.
  - mode 1: control<=start_word, dwell_cnt<=dwell, dir unchanged.
  - mode 2: swap end word (stop↔start), flip dir, dwell_cnt<=dwell, then step back from the current word.
- step==0: treated as a jump straight to the end word on the next update; no hang.
- start_word==stop_word:
  - Word held for dwell+1 cycles, then the end-reached action runs.
  - mode 1/2 hold the word indefinitely, re-dwelling.
- dwell==0: control updates every cycle.
- abort (any state, synchronous):
  - state<=IDLE, busy<=0, no done pulse, control holds its value.
  - abort and start in the same cycle: abort wins and start is ignored.
- start while busy: ignored.
- Asynchronous reset mid-sweep returns all outputs to their reset values immediately.
- Latency: start edge → control=start_word on the same edge (visible next cycle); last word held exactly dwell+1 cycles before done.
- The sweep is not synchronised to NCO phase; the word may change mid-period.

Test Plan:
- Reset: assert reset=0 mid-sweep → control=FFFF, busy=0, done=0 immediately, without a clock edge.
- Up one-shot: start=100, stop=110, step=4, dwell=2, mode=0 → control 100,104,108,110, each for 3 cycles; then done high for 1 cycle and busy low; control stays 110.
- Down, with saturation and overflow:
  - start=50, stop=40, step=3, dwell=0 → control 50,47,44,41,40, then done.
  - start=FFF0, stop=FFFF, step=0020 → FFF0 then FFFF, with no wrap.
- Repeat: start=10, stop=12, step=1, dwell=1, mode=1 → 10,10,11,11,12,12,10,10,… with no done and busy held high.
- Triangle: start=10, stop=13, step=2, dwell=0, mode=2 → 10,12,13,11,10,12,13,…
- Abort and start-while-busy:
  - Mid-sweep start pulse → ignored.
  - abort at control=104 → busy=0 next cycle, control stays 104, no done.
  - Simultaneous start+abort in IDLE → remains IDLE.
